rvm_axi4_sram_slave: RTL and testbench

AXI4 memory responder that terminates the rvm_core_axi4 master port on on-chip block RAM, replacing the DDR3 controller for simulation and for bring-up builds without external memory. Fixed 32-bit data and single transaction ID. Independent read and write state machines drive a dual-port RAM. Returns OKAY, SLVERR or DECERR per AXI4 rules.

---
 rtl/rvm_axi4_pkg.sv | 42 ++++
 rtl/rvm_axi4_sram_slave_if.sv | 56 +++++
 rtl/rvm_axi4_ram_dp.sv | 37 +++
 rtl/rvm_axi4_sram_slave.sv | 189 ++++++++++++++++++
 tb/tb_rvm_axi4_sram_slave.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvm_axi4_pkg.sv
// Shared definitions for the AXI4 SRAM responder.
//   - burst type and response encodings
//   - write / read FSM state types, also exported on the debug ports
//   - address helpers used by both channel FSMs
package rvm_axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_e;

    // Word index relative to the RAM base; the wrap-around of the
    // subtraction is caught separately by the addr >= base test.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // FIXED keeps the address, everything else steps one word. WRAP
    // bursts are never serviced, so stepping them linearly is harmless.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + 32'd4;
    endfunction

endpackage

// File: rtl/rvm_axi4_sram_slave_if.sv
// AXI4 bus bundle between the core master port and the SRAM responder.
// Single ID, 32-bit data, full-word transfers only.
//   master modport: drives AW/W/AR and BREADY/RREADY
//   slave modport : drives AWREADY/WREADY/B*/ARREADY/R*
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where VALID and READY are both 1; a source raising VALID keeps it
// and its payload unchanged until that edge, and VALID never waits on READY.
interface rvm_axi4_sram_slave_if;

    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic        BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic        RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BID, BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
        input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );

endinterface

// File: rtl/rvm_axi4_ram_dp.sv
// Dual-port 32-bit block RAM.
//   clk              : clock
//   a_be/a_addr/a_wdata : port A, synchronous write, one enable per byte
//   b_en/b_addr/b_rdata : port B, synchronous read, 1-cycle latency;
//                         b_rdata holds while b_en is low
// A same-cycle write and read of one word returns the old contents.
// No reset: contents survive the bus reset.
module rvm_axi4_ram_dp #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    a_be,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_be[i]) begin
                mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 responder backed by on-chip RAM, standing in for the DDR3 controller.
//   ACLK, ARESET : clock, synchronous active-high reset
//   axi          : AXI4 slave bundle (AW/W/B/AR/R)
//   dbg_w_state  : write FSM state
//   dbg_r_state  : read FSM state
// Write and read channels run independent FSMs on separate RAM ports.
// Channel outputs are pure decodes of registered state, forced low while
// ARESET is high so the bus is quiet for the whole reset window.
module rvm_axi4_sram_slave
    import rvm_axi4_pkg::*;
#(
    parameter int          MEM_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    rvm_axi4_sram_slave_if.slave axi,
    output w_state_e             dbg_w_state,
    output r_state_e             dbg_r_state
);

    localparam int AW = $clog2(MEM_DEPTH);

    // write channel state
    w_state_e    w_state;
    logic [31:0] w_addr;
    logic [7:0]  w_cnt;
    logic [1:0]  w_burst;
    logic        w_dec;
    logic        w_slv;
    logic [1:0]  bresp_q;

    // read channel state
    r_state_e    r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [1:0]  r_burst;
    logic        r_zero;
    logic [1:0]  rresp_q;

    logic [31:0] w_idx;
    logic [31:0] r_idx;
    logic        w_in_range;
    logic        r_in_range;
    logic        w_last_beat;
    logic        w_dec_next;
    logic        w_slv_next;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic        ram_re;
    logic [31:0] ram_q;

    always_comb begin
        w_idx       = word_index(w_addr, BASE_ADDR);
        r_idx       = word_index(r_addr, BASE_ADDR);
        w_in_range  = (w_addr >= BASE_ADDR) && (w_idx < 32'(MEM_DEPTH));
        r_in_range  = (r_addr >= BASE_ADDR) && (r_idx < 32'(MEM_DEPTH));
        w_last_beat = (w_cnt == 8'd0);
        // Error flags including the beat now on the bus. burst[1] covers
        // WRAP and the reserved encoding; both are refused.
        w_dec_next  = w_dec | ~w_in_range;
        w_slv_next  = w_slv | w_burst[1] | (axi.WLAST != w_last_beat);
        ram_we      = axi.WREADY && axi.WVALID && w_in_range && !w_burst[1];
        ram_be      = ram_we ? axi.WSTRB : 4'b0000;
        ram_re      = (r_state == R_FETCH);
    end

    assign axi.AWREADY = (w_state == W_IDLE) && !ARESET;
    assign axi.WREADY  = (w_state == W_DATA) && !ARESET;
    assign axi.BVALID  = (w_state == W_RESP) && !ARESET;
    assign axi.BRESP   = axi.BVALID ? bresp_q : RESP_OKAY;
    assign axi.BID     = 1'b0;

    assign axi.ARREADY = (r_state == R_IDLE) && !ARESET;
    assign axi.RVALID  = (r_state == R_DATA) && !ARESET;
    assign axi.RRESP   = axi.RVALID ? rresp_q : RESP_OKAY;
    // RAM output holds while no fetch is issued, so RDATA is stable in R_DATA.
    assign axi.RDATA   = (axi.RVALID && !r_zero) ? ram_q : 32'h0;
    assign axi.RLAST   = axi.RVALID && (r_beat == r_len);
    assign axi.RID     = 1'b0;

    assign dbg_w_state = w_state;
    assign dbg_r_state = r_state;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi.AWVALID) begin
                        w_addr  <= axi.AWADDR;
                        w_cnt   <= axi.AWLEN;
                        w_burst <= axi.AWBURST;
                        w_dec   <= 1'b0;
                        w_slv   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.WVALID) begin
                        w_dec <= w_dec_next;
                        w_slv <= w_slv_next;
                        // Burst length comes from AWLEN only; WLAST is
                        // merely cross-checked.
                        if (w_last_beat) begin
                            bresp_q <= w_dec_next ? RESP_DECERR :
                                       (w_slv_next ? RESP_SLVERR : RESP_OKAY);
                            w_state <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt - 8'd1;
                            w_addr <= next_addr(w_addr, w_burst);
                        end
                    end
                end
                W_RESP: begin
                    if (axi.BREADY) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= BURST_INCR;
            r_zero  <= 1'b0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi.ARVALID) begin
                        r_addr  <= axi.ARADDR;
                        r_len   <= axi.ARLEN;
                        r_burst <= axi.ARBURST;
                        r_beat  <= 8'd0;
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Response is per beat: decided as the RAM read issues.
                    r_zero  <= r_burst[1] | ~r_in_range;
                    rresp_q <= !r_in_range ? RESP_DECERR :
                               (r_burst[1] ? RESP_SLVERR : RESP_OKAY);
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (axi.RREADY) begin
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= next_addr(r_addr, r_burst);
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    rvm_axi4_ram_dp #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (ACLK),
        .a_be    (ram_be),
        .a_addr  (w_idx[AW-1:0]),
        .a_wdata (axi.WDATA),
        .b_en    (ram_re),
        .b_addr  (r_idx[AW-1:0]),
        .b_rdata (ram_q)
    );

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
module tb_rvm_axi4_sram_slave;
    import rvm_axi4_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    rvm_axi4_sram_slave_if axi();
    w_state_e dbg_w;
    r_state_e dbg_r;

    int checks = 0;
    int errors = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];

    always #5 ACLK = ~ACLK;

    rvm_axi4_sram_slave #(
        .MEM_DEPTH (1024),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .axi         (axi),
        .dbg_w_state (dbg_w),
        .dbg_r_state (dbg_r)
    );

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int wlast_at,
                             output logic [1:0] resp, output int beats,
                             output bit timing_ok);
        int n;
        timing_ok = 1'b1;
        beats = 0;
        @(posedge ACLK); #1;
        axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!axi.AWREADY && n < 20) begin n++; @(negedge ACLK); end
        if (!axi.AWREADY) timing_ok = 1'b0;
        @(posedge ACLK); #1;
        axi.AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            axi.WVALID = 1'b1; axi.WDATA = wd[b]; axi.WSTRB = ws[b];
            axi.WLAST = (b == wlast_at);
            @(negedge ACLK);
            if (axi.WREADY) beats++; else timing_ok = 1'b0;
            @(posedge ACLK); #1;
        end
        axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        if (axi.WREADY) timing_ok = 1'b0;
        while (!axi.BVALID && n < 20) begin timing_ok = 1'b0; n++; @(negedge ACLK); end
        resp = axi.BRESP;
        @(posedge ACLK); #1;
        axi.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit stall,
                            output int nbeats, output bit timing_ok,
                            output bit stable_ok);
        int n;
        int gap;
        timing_ok = 1'b1;
        stable_ok = 1'b1;
        nbeats = 0;
        for (int i = 0; i < 16; i++) begin rd[i] = 32'hx; rr[i] = 2'bx; rl[i] = 1'bx; end
        @(posedge ACLK); #1;
        axi.ARADDR = addr; axi.ARLEN = len; axi.ARBURST = burst; axi.ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!axi.ARREADY && n < 20) begin n++; @(negedge ACLK); end
        if (!axi.ARREADY) timing_ok = 1'b0;
        @(posedge ACLK); #1;
        axi.ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            gap = 0;
            @(negedge ACLK);
            while (!axi.RVALID && gap < 20) begin gap++; @(negedge ACLK); end
            if (!axi.RVALID) begin timing_ok = 1'b0; break; end
            if (gap != 1) timing_ok = 1'b0;
            rd[b] = axi.RDATA; rr[b] = axi.RRESP; rl[b] = axi.RLAST;
            if (stall) begin
                @(posedge ACLK); #1;
                @(negedge ACLK);
                if (!axi.RVALID || axi.RDATA !== rd[b] || axi.RRESP !== rr[b] ||
                    axi.RLAST !== rl[b]) stable_ok = 1'b0;
            end
            axi.RREADY = 1'b1;
            @(posedge ACLK); #1;
            axi.RREADY = 1'b0;
            nbeats++;
        end
        @(negedge ACLK);
        if (axi.RVALID) timing_ok = 1'b0;
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID, axi.RLAST} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID, axi.RLAST});
        end
        checks++;
        if ({axi.BRESP, axi.RRESP, axi.RDATA} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data got bresp %b rresp %b rdata %h exp 0", axi.BRESP, axi.RRESP, axi.RDATA);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({axi.AWREADY, axi.ARREADY, axi.WREADY, axi.RVALID} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release got aw/ar/w/rv %b exp 1100",
                     {axi.AWREADY, axi.ARREADY, axi.WREADY, axi.RVALID});
        end
        checks++;
        if ({axi.BID, axi.RID} !== 2'b00) begin
            errors++;
            $display("FAIL ids got %b exp 00", {axi.BID, axi.RID});
        end
    endtask

    task automatic test_single();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(32'h10, 8'd0, 2'b01, 0, resp, beats, tok);
        checks++;
        if (resp !== 2'b00 || beats != 1 || !tok) begin
            errors++;
            $display("FAIL single_write got resp %b beats %0d timing %0d exp 00 1 1", resp, beats, tok);
        end
        axi_read(32'h10, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'hDEADBEEF || rr[0] !== 2'b00 || rl[0] !== 1'b1 || !tok || nb != 1) begin
            errors++;
            $display("FAIL single_read got %h/%b/%b timing %0d exp deadbeef/00/1 1", rd[0], rr[0], rl[0], tok);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        axi_write(32'h20, 8'd0, 2'b01, 0, resp, beats, tok);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(32'h20, 8'd0, 2'b01, 0, resp, beats, tok);
        axi_read(32'h20, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'hAA22CC44 || rr[0] !== 2'b00) begin
            errors++;
            $display("FAIL strobe got %h/%b exp aa22cc44/00", rd[0], rr[0]);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h100, 8'd3, 2'b01, 3, resp, beats, tok);
        checks++;
        if (resp !== 2'b00 || beats != 4 || !tok) begin
            errors++;
            $display("FAIL incr_write got resp %b beats %0d timing %0d exp 00 4 1", resp, beats, tok);
        end
        axi_read(32'h100, 8'd3, 2'b01, 1'b1, nb, tok, sok);
        checks++;
        if (!tok || !sok || nb != 4) begin
            errors++;
            $display("FAIL incr_read_hs got timing %0d stable %0d beats %0d exp 1 1 4", tok, sok, nb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 32'(i + 1) || rr[i] !== 2'b00 || rl[i] !== (i == 3)) begin
                errors++;
                $display("FAIL incr_beat%0d got %h/%b/%b exp %h/00/%b", i, rd[i], rr[i], rl[i], 32'(i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_fixed();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        axi_write(32'h44, 8'd0, 2'b01, 0, resp, beats, tok);
        wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        axi_write(32'h40, 8'd2, 2'b00, 2, resp, beats, tok);
        checks++;
        if (resp !== 2'b00 || beats != 3) begin
            errors++;
            $display("FAIL fixed_write got resp %b beats %0d exp 00 3", resp, beats);
        end
        axi_read(32'h40, 8'd1, 2'b00, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'd7 || rd[1] !== 32'd7 || rl[0] !== 1'b0 || rl[1] !== 1'b1 || !tok) begin
            errors++;
            $display("FAIL fixed_read got %h %h last %b%b exp 7 7 last 01", rd[0], rd[1], rl[0], rl[1]);
        end
        axi_read(32'h44, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL fixed_neighbour got %h exp 12345678", rd[0]);
        end
    endtask

    task automatic test_range();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        ws[0] = 4'hF; ws[1] = 4'hF;
        wd[0] = 32'h600DCAFE;
        axi_write(32'h0, 8'd0, 2'b01, 0, resp, beats, tok);
        wd[0] = 32'hCAFEF00D;
        axi_write(32'hFFC, 8'd0, 2'b01, 0, resp, beats, tok);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL range_last_word_write got %b exp 00", resp);
        end
        wd[0] = 32'hFFFFFFFF;
        axi_write(32'h1000, 8'd0, 2'b01, 0, resp, beats, tok);
        checks++;
        if (resp !== 2'b11 || beats != 1) begin
            errors++;
            $display("FAIL range_oor_write got %b beats %0d exp 11 1", resp, beats);
        end
        axi_read(32'h1000, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h0 || rr[0] !== 2'b11 || rl[0] !== 1'b1) begin
            errors++;
            $display("FAIL range_oor_read got %h/%b/%b exp 0/11/1", rd[0], rr[0], rl[0]);
        end
        axi_read(32'h0, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h600DCAFE) begin
            errors++;
            $display("FAIL range_no_alias got %h exp 600dcafe", rd[0]);
        end
        axi_read(32'hFFC, 8'd1, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'hCAFEF00D || rr[0] !== 2'b00 || rd[1] !== 32'h0 || rr[1] !== 2'b11 || rl[1] !== 1'b1) begin
            errors++;
            $display("FAIL range_cross_read got %h/%b %h/%b exp cafef00d/00 0/11", rd[0], rr[0], rd[1], rr[1]);
        end
        wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A;
        axi_write(32'hFFC, 8'd1, 2'b01, 1, resp, beats, tok);
        axi_read(32'hFFC, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (resp !== 2'b11 || rd[0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL range_cross_write got resp %b data %h exp 11 a5a5a5a5", resp, rd[0]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; int beats; bit tok; bit sok; int nb;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h31 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h300, 8'd3, 2'b01, 1, resp, beats, tok);
        checks++;
        if (resp !== 2'b10 || beats != 4 || !tok) begin
            errors++;
            $display("FAIL early_wlast got resp %b beats %0d timing %0d exp 10 4 1", resp, beats, tok);
        end
        axi_read(32'h30C, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h34) begin
            errors++;
            $display("FAIL early_wlast_data got %h exp 00000034", rd[0]);
        end
        axi_write(32'h310, 8'd1, 2'b01, -1, resp, beats, tok);
        checks++;
        if (resp !== 2'b10) begin
            errors++;
            $display("FAIL missing_wlast got %b exp 10", resp);
        end
        wd[0] = 32'h0; wd[1] = 32'h0;
        axi_write(32'h10, 8'd1, 2'b10, 1, resp, beats, tok);
        axi_read(32'h10, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (resp !== 2'b10 || rd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wrap_write got resp %b data %h exp 10 deadbeef", resp, rd[0]);
        end
        axi_read(32'h100, 8'd1, 2'b10, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h0 || rd[1] !== 32'h0 || rr[0] !== 2'b10 || rr[1] !== 2'b10 || rl[1] !== 1'b1 || nb != 2) begin
            errors++;
            $display("FAIL wrap_read got %h/%b %h/%b exp 0/10 0/10", rd[0], rr[0], rd[1], rr[1]);
        end
        axi_write(32'hFFC, 8'd1, 2'b01, 0, resp, beats, tok);
        checks++;
        if (resp !== 2'b11) begin
            errors++;
            $display("FAIL dec_over_slv got %b exp 11", resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit tok; bit sok; int nb;
        @(posedge ACLK); #1;
        axi.ARADDR = 32'h100; axi.ARLEN = 8'd3; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
        @(posedge ACLK); #1;
        axi.ARVALID = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if (axi.RVALID !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_rvalid got %b exp 1", axi.RVALID);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({axi.RVALID, axi.ARREADY, axi.RDATA} !== 34'h0) begin
            errors++;
            $display("FAIL rst_mid_read got rvalid %b arready %b rdata %h exp 0 0 0", axi.RVALID, axi.ARREADY, axi.RDATA);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({axi.ARREADY, axi.AWREADY, axi.RVALID} !== 3'b110) begin
            errors++;
            $display("FAIL rst_release got ar/aw/rv %b exp 110", {axi.ARREADY, axi.AWREADY, axi.RVALID});
        end
        axi_read(32'h10, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'hDEADBEEF || rr[0] !== 2'b00 || !tok) begin
            errors++;
            $display("FAIL rst_fresh_read got %h/%b timing %0d exp deadbeef/00 1", rd[0], rr[0], tok);
        end
        // abandon a write burst after its first beat
        @(posedge ACLK); #1;
        axi.AWADDR = 32'h500; axi.AWLEN = 8'd3; axi.AWBURST = 2'b01; axi.AWVALID = 1'b1;
        @(posedge ACLK); #1;
        axi.AWVALID = 1'b0;
        axi.WVALID = 1'b1; axi.WDATA = 32'h11111111; axi.WSTRB = 4'hF; axi.WLAST = 1'b0;
        @(posedge ACLK); #1;
        axi.WVALID = 1'b0;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({axi.BVALID, axi.WREADY, axi.AWREADY} !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_write got bv/w/aw %b exp 001", {axi.BVALID, axi.WREADY, axi.AWREADY});
        end
        axi_read(32'h500, 8'd0, 2'b01, 1'b0, nb, tok, sok);
        checks++;
        if (rd[0] !== 32'h11111111) begin
            errors++;
            $display("FAIL rst_kept_beat got %h exp 11111111", rd[0]);
        end
    endtask

    initial begin
        axi.AWADDR = '0; axi.AWLEN = '0; axi.AWBURST = 2'b01; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
        axi.BREADY = 1'b0;
        axi.ARADDR = '0; axi.ARLEN = '0; axi.ARBURST = 2'b01; axi.ARVALID = 1'b0;
        axi.RREADY = 1'b0;
        test_reset();
        test_single();
        test_strobe();
        test_incr_burst();
        test_fixed();
        test_range();
        test_errors();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
